// File: rtl/sd_sector_streamer_if.sv
`timescale 1ns/1ps
// Control, SD-card read port and byte-stream port of the sector streamer.
interface sd_sector_streamer_if;
    logic        start;
    logic        stop;
    logic        init_finished;
    logic        sd_rd_req;
    logic [31:0] sd_block_addr;
    logic [7:0]  sd_dout;
    logic        sd_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] cur_blk;
    logic        busy;
    logic [15:0] sectors_done;

    modport slave (
        input  start, stop, init_finished,
        input  sd_dout, sd_valid, out_ready,
        output sd_rd_req, sd_block_addr,
        output out_data, out_valid, out_last,
        output cur_blk, busy, sectors_done
    );

    modport master (
        output start, stop, init_finished,
        output sd_dout, sd_valid, out_ready,
        input  sd_rd_req, sd_block_addr,
        input  out_data, out_valid, out_last,
        input  cur_blk, busy, sectors_done
    );
endinterface

// File: rtl/sd_sector_streamer.sv
`timescale 1ns/1ps
// Fetches consecutive 512-byte SD blocks into a local buffer and
// replays each one as a back-pressured byte stream.
module sd_sector_streamer #(
    parameter logic [31:0] START_BLK = 32'h2000
) (
    input  logic clk,
    input  logic reset,
    sd_sector_streamer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        DRAIN,
        NEXT
    } state_t;

    state_t      state;
    logic [7:0]  mem [512];
    logic [9:0]  wr_cnt;
    logic [8:0]  rd_ptr;
    logic        stop_pend;
    logic        rd_req;
    logic [31:0] blk_addr;
    logic [31:0] blk;
    logic [7:0]  data;
    logic        valid;
    logic        last;
    logic [15:0] done;
    logic        wr_en;
    logic        take;

    assign wr_en = (state == FILL) && bus.sd_valid && !wr_cnt[9];
    assign take  = valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_cnt[8:0]] <= bus.sd_dout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            stop_pend <= 1'b0;
            rd_req    <= 1'b0;
            blk_addr  <= START_BLK;
            blk       <= START_BLK;
            data      <= 8'h00;
            valid     <= 1'b0;
            last      <= 1'b0;
            done      <= 16'h0000;
        end else begin
            rd_req <= 1'b0;
            if (bus.stop && state != IDLE)
                stop_pend <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.start && bus.init_finished) begin
                        state    <= REQ;
                        rd_req   <= 1'b1;
                        blk_addr <= blk;
                    end
                end
                REQ: begin
                    wr_cnt <= '0;
                    rd_ptr <= '0;
                    state  <= FILL;
                end
                FILL: begin
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + 10'd1;
                        if (wr_cnt == 10'd511)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // rd_ptr runs one byte ahead of the presented one
                    if (take && last) begin
                        valid <= 1'b0;
                        last  <= 1'b0;
                        state <= NEXT;
                    end else if (!valid || bus.out_ready) begin
                        data   <= mem[rd_ptr];
                        last   <= (rd_ptr == 9'd511);
                        valid  <= 1'b1;
                        rd_ptr <= rd_ptr + 9'd1;
                    end
                end
                NEXT: begin
                    blk <= blk + 32'd1;
                    if (done != 16'hFFFF)
                        done <= done + 16'd1;
                    if (stop_pend || bus.stop) begin
                        stop_pend <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state    <= REQ;
                        rd_req   <= 1'b1;
                        blk_addr <= blk + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sd_rd_req     = rd_req;
    assign bus.sd_block_addr = blk_addr;
    assign bus.out_data      = data;
    assign bus.out_valid     = valid;
    assign bus.out_last      = last;
    assign bus.cur_blk       = blk;
    assign bus.busy          = (state != IDLE);
    assign bus.sectors_done  = done;
endmodule

// File: doc/sd_sector_streamer.md
# sd_sector_streamer

Sector fetch stage between the `sd_card` SPI controller and the downstream byte consumers, such as the tag/word scanner. On `start`, it requests consecutive 512-byte blocks starting at `START_BLK` and captures each block into an internal 512×8 buffer. It then replays each block as a valid/ready byte stream with a per-sector `out_last` marker. This replaces ad-hoc SRAM address muxing in top-level designs with a single back-pressured byte source.

## Interface
- `START_BLK`, default 32'h2000: first block address after reset.
- `clk`  in  1  system clock, 100 MHz domain. The `sd_card` data side runs on the same clock once `init_finished` is high.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins streaming at `cur_blk`.
- `stop`  in  1  single-cycle pulse that halts after the current sector has been fully drained.
- `init_finished`  in  1  from `sd_card`. `start` is ignored while this is low.
- `sd_rd_req`  out  1  read request to `sd_card`. Registered; high for exactly one cycle per block.
- `sd_block_addr`  out  32  block address to `sd_card`. Registered and stable from the `sd_rd_req` cycle until the fill completes.
- `sd_dout`  in  8  byte from `sd_card`.
- `sd_valid`  in  1  byte strobe from `sd_card`.
- `out_data`  out  8  streamed byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte when both `out_valid` and `out_ready` are high.
- `out_last`  out  1  qualifies byte 511 of the current sector.
- `cur_blk`  out  32  block currently being filled or drained.
- `busy`  out  1  high whenever the state is not IDLE.
- `sectors_done`  out  16  count of fully drained sectors. Saturates at 16'hFFFF.

## Operation
State machine with five states: IDLE, REQ, FILL, DRAIN, NEXT.

- **IDLE**
  - Goes to REQ on `start && init_finished`.
  - `sd_valid` strobes are ignored and nothing is written to the buffer.
- **REQ**
  - Asserts `sd_rd_req` for one cycle with `sd_block_addr` = `cur_blk`.
  - Clears the 10-bit fill counter `wr_cnt`.
  - Always goes to FILL on the next cycle.
- **FILL**
  - Each `sd_valid` writes `sd_dout` to buf[`wr_cnt`], then `wr_cnt` increments.
  - When `wr_cnt` reaches 512, goes to DRAIN.
  - `sd_valid` after the 512th byte is ignored.
- **DRAIN**
  - Reads out buf[0..511] in order through the valid/ready port.
  - `out_last` is high only while byte 511 is presented.
  - The handshake on byte 511 goes to NEXT.
- **NEXT**
  - Increments `sectors_done` (saturating).
  - If a stop is pending, clears it and goes to IDLE; `cur_blk` advances by 1 either way.
  - Otherwise `cur_blk` increments by 1 and the state goes to REQ.
  - `cur_blk` wraps from 32'hFFFFFFFF to 0.
- **stop handling**
  - A `stop` pulse in REQ, FILL, DRAIN or NEXT sets `stop_pend`.
  - `stop` in IDLE has no effect.
  - The current sector is never truncated.
- **start handling**
  - `start` while `busy` is high is ignored.
  - A restart from IDLE resumes at `cur_blk` (the block after the last drained one). Only `reset` restores `START_BLK`.
- **Stream rules**
  - Once `out_valid` is high, `out_data` and `out_last` are held stable until the handshake completes. No byte is dropped or duplicated.
  - `out_valid` is 0 outside DRAIN.

## Timing
- **Reset values:**
  - `sd_rd_req`, `out_valid`, `out_last`, `busy` = 0
  - `out_data` = 8'h00, `sectors_done` = 0
  - `sd_block_addr` = `cur_blk` = `START_BLK`
  - State = IDLE, `stop_pend` = 0
- **Reset mid-operation:** asserting `reset` in any state returns all of the above immediately, without waiting for a clock edge.
- **Start latency:** with `start` sampled high at edge N, `sd_rd_req` = 1 during cycle N+1 and `busy` = 1 from N+1.
- **Fill-to-drain latency:** the 512th `sd_valid` is sampled at edge M, and the first `out_valid` = 1 appears at cycle M+2 (one prefetch cycle for the synchronous buffer read).
- **Throughput:** with `out_ready` held high, one byte per cycle, so 512 consecutive cycles per sector. Buffer reads use look-ahead addressing so no bubbles occur.
- **Back-to-back sectors:** the next `sd_rd_req` is asserted 2 cycles after the `out_last` handshake (NEXT, then REQ).
- **Simultaneous events:** `stop` arriving in the same cycle as the `out_last` handshake still counts as pending, and the block returns to IDLE.

## Test plan
- **Reset values:** reset asserted → all outputs hold their reset values; `sd_block_addr` = 32'h2000; 20 `sd_valid` strobes cause no `out_valid`.
- **Single sector:** `init_finished` = 1, `start` pulse, `out_ready` = 1, model feeds bytes i mod 256 → exactly one `sd_rd_req` with addr 32'h2000; 512 output bytes matching the input; `out_last` only on byte 511; next `sd_rd_req` with addr 32'h2001.
- **Back-pressure:** `out_ready` pseudo-random at 30% duty → 512 bytes in order, `out_data` stable while stalled, `sectors_done` = 1 after the sector.
- **Stop mid-fill:** `stop` pulse in FILL at byte 100 → sector 32'h2000 drains fully, then IDLE, `busy` = 0, `cur_blk` = 32'h2001; a new `start` requests 32'h2001.
- **Start gating:** `start` with `init_finished` = 0 → no `sd_rd_req`, `busy` stays 0; `start` pulses while busy do not add extra requests.
- **Reset mid-drain:** `reset` at byte 300 of the drain → `out_valid` = 0 immediately; `cur_blk` = 32'h2000 and `sectors_done` = 0 after release.
